// File: rtl/alu_exec_unit.sv
// ALU execution unit: one opcode per handshake, registered result with Z/C/V flags.
// Optional feature macro ALU_MUL_EN adds the WIDTH-cycle shift-add MUL path (opcode 1000).
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1000;
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic             ready_reg;
    logic [3:0]       opcode_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             z_reg, c_reg, v_reg, ill_reg;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;
    logic [WIDTH:0]   add_sum, sub_sum;
    logic             accept;
    logic             mul_last;

    // ready_reg keeps in_ready low until the first clock after reset release
    assign in_ready  = ready_reg && (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign result    = result_reg;
    assign flag_z    = z_reg;
    assign flag_c    = c_reg;
    assign flag_v    = v_reg;
    assign illegal   = ill_reg;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc_reg, mcand_reg, mplier_reg, acc_next;
    logic [SHW-1:0]   cnt_reg;
    localparam logic [SHW-1:0] MUL_LAST = SHW'(WIDTH - 1);

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign mul_last = (cnt_reg == MUL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else if (accept) begin
            acc_reg    <= '0;
            mcand_reg  <= op_a;
            mplier_reg <= op_b;
            cnt_reg    <= '0;
        end else if (state_reg == MUL) begin
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end
`else
    assign mul_last = 1'b0;
`endif

    // SUB uses A + ~B + 1 so bit WIDTH is directly the NOT-borrow carry
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        add_sum = {1'b0, a_reg} + {1'b0, b_reg};
        sub_sum = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
        case (opcode_reg)
            OP_AND:  alu_res = a_reg & b_reg;
            OP_OR:   alu_res = a_reg | b_reg;
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (sub_sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            OP_SRL:  alu_res = a_reg >> b_reg[SHW-1:0];
            OP_NOR:  alu_res = ~(a_reg | b_reg);
            OP_PASS: alu_res = a_reg;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    state_next = (OPCODE == OP_MUL) ? MUL : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            EXEC: state_next = DONE;
`ifdef ALU_MUL_EN
            MUL:  if (mul_last) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ready_reg  <= 1'b0;
            opcode_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            z_reg      <= 1'b0;
            c_reg      <= 1'b0;
            v_reg      <= 1'b0;
            ill_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= 1'b1;
            if (accept) begin
                opcode_reg <= OPCODE;
                a_reg      <= op_a;
                b_reg      <= op_b;
            end
            if (state_reg == EXEC) begin
                result_reg <= alu_res;
                z_reg      <= (alu_res == '0) && !alu_ill;
                c_reg      <= alu_c;
                v_reg      <= alu_v;
                ill_reg    <= alu_ill;
            end
`ifdef ALU_MUL_EN
            if (state_reg == MUL && mul_last) begin
                result_reg <= acc_next;
                z_reg      <= (acc_next == '0);
                c_reg      <= 1'b0;
                v_reg      <= 1'b0;
                ill_reg    <= 1'b0;
            end
`endif
        end
    end
endmodule
